// File: rtl/tw_seq_bank.sv
// Twiddle bank: per-stage/per-group tables plus a per-stage constant, streamed by an idx/rep/grp sequencer.
// Latency: 1 cycle from address (counters, stage_counter) to Q/Q_valid/Q_const.
// Backpressure: none; CEN=1 freezes the sequencer, run=0 restarts the sweep of the current group.
module tw_seq_bank #(
  parameter int SC_WIDTH   = 3,
  parameter int NUM_STAGES = 4,
  parameter int P_WIDTH    = 128,
  parameter int HALF_W     = 64,
  parameter int DEPTH      = 4,
  parameter int MAX_GROUPS = 4,
  parameter int REPEAT     = 16,
  parameter logic [P_WIDTH-1:0] IDLE_WORD = 128'h1_0000000000000001,
  localparam int GW = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [SC_WIDTH-1:0] stage_counter,
  input  logic                CEN,
  input  logic                run,
  input  logic                wr_en,
  input  logic [1:0]          wr_kind,
  input  logic                wr_hi,
  input  logic [SC_WIDTH-1:0] wr_stage,
  input  logic [GW-1:0]       wr_grp,
  input  logic [IW-1:0]       wr_idx,
  input  logic [HALF_W-1:0]   wr_data,
  output logic [P_WIDTH-1:0]  Q,
  output logic                Q_valid,
  output logic [P_WIDTH-1:0]  Q_const,
  output logic [GW-1:0]       grp_idx,
  output logic                seq_wrap
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int CW = $clog2(MAX_GROUPS + 1);
  localparam logic [SC_WIDTH:0] NS_L = (SC_WIDTH+1)'(NUM_STAGES);

  // storage
  logic [P_WIDTH-1:0] tbl_q   [NUM_STAGES][MAX_GROUPS][DEPTH];
  logic [P_WIDTH-1:0] tbl_d   [NUM_STAGES][MAX_GROUPS][DEPTH];
  logic [P_WIDTH-1:0] const_q [NUM_STAGES];
  logic [P_WIDTH-1:0] const_d [NUM_STAGES];
  logic [CW-1:0]      gnum_q  [NUM_STAGES];
  logic [CW-1:0]      gnum_d  [NUM_STAGES];

  // sequencer and output registers
  logic [SC_WIDTH-1:0] stage_q, stage_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       rep_q, rep_d;
  logic [GW-1:0]       grp_q, grp_d;
  logic                seq_wrap_q, seq_wrap_d;
  logic [P_WIDTH-1:0]  q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic [P_WIDTH-1:0]  q_const_q, q_const_d;

  logic          s_ok, wr_ok, rd_en;
  logic [SW-1:0] s_idx, ws_idx;
  logic [CW-1:0] gnum_cur;
  logic          grp_over, grp_last, idx_last, rep_last;

  assign s_ok     = {1'b0, stage_counter} < NS_L;
  assign wr_ok    = wr_en && ({1'b0, wr_stage} < NS_L);
  assign s_idx    = stage_counter[SW-1:0];
  assign ws_idx   = wr_stage[SW-1:0];
  assign rd_en    = !CEN && s_ok;
  // Stages without a table behave as single-group stages so grp stays at 0.
  assign gnum_cur = s_ok ? gnum_q[s_idx] : CW'(1);
  assign grp_over = CW'(grp_q) >= gnum_cur;
  assign grp_last = CW'(grp_q) == (gnum_cur - CW'(1));
  assign idx_last = idx_q == IW'(DEPTH - 1);
  assign rep_last = rep_q == RW'(REPEAT - 1);

  // Run-time writes; readers see the registered (old) contents this cycle.
  always_comb begin
    tbl_d   = tbl_q;
    const_d = const_q;
    gnum_d  = gnum_q;
    if (wr_ok) begin
      case (wr_kind)
        2'd0: begin
          if (wr_hi) tbl_d[ws_idx][wr_grp][wr_idx][P_WIDTH-1:HALF_W] = wr_data;
          else       tbl_d[ws_idx][wr_grp][wr_idx][HALF_W-1:0]       = wr_data;
        end
        2'd1: begin
          if (wr_hi) const_d[ws_idx][P_WIDTH-1:HALF_W] = wr_data;
          else       const_d[ws_idx][HALF_W-1:0]       = wr_data;
        end
        2'd2: begin
          if (wr_data != '0 && wr_data <= HALF_W'(MAX_GROUPS))
            gnum_d[ws_idx] = wr_data[CW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Sequencer next state: stage change clears, CEN freezes, run=0 restarts the sweep.
  always_comb begin
    stage_d    = stage_counter;
    idx_d      = idx_q;
    rep_d      = rep_q;
    grp_d      = grp_q;
    seq_wrap_d = 1'b0;
    if (stage_counter != stage_q) begin
      idx_d = '0;
      rep_d = '0;
      grp_d = '0;
    end else begin
      if (!CEN) begin
        if (!run) begin
          idx_d = '0;
          rep_d = '0;
        end else begin
          idx_d = idx_last ? '0 : idx_q + IW'(1);
          if (idx_last) begin
            rep_d = rep_last ? '0 : rep_q + RW'(1);
            if (rep_last && !grp_over) begin
              if (grp_last) begin
                grp_d      = '0;
                seq_wrap_d = 1'b1;
              end else begin
                grp_d = grp_q + GW'(1);
              end
            end
          end
        end
      end
      // A group count lowered below the live group pulls it back silently.
      if (grp_over) grp_d = '0;
    end
  end

  // Read path, addressed by the counters as they stood before this edge.
  always_comb begin
    q_d       = IDLE_WORD;
    q_valid_d = 1'b0;
    q_const_d = q_const_q;
    if (rd_en) begin
      q_d       = tbl_q[s_idx][grp_q][idx_q];
      q_valid_d = run;
      q_const_d = const_q[s_idx];
    end
  end

  // Table, constant and group-count storage; reset restores the identity contents.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        const_q[s] <= IDLE_WORD;
        gnum_q[s]  <= CW'(1);
        for (int g = 0; g < MAX_GROUPS; g++)
          for (int i = 0; i < DEPTH; i++)
            tbl_q[s][g][i] <= IDLE_WORD;
      end
    end else begin
      tbl_q   <= tbl_d;
      const_q <= const_d;
      gnum_q  <= gnum_d;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      stage_q    <= '0;
      idx_q      <= '0;
      rep_q      <= '0;
      grp_q      <= '0;
      seq_wrap_q <= 1'b0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      q_const_q  <= '0;
    end else begin
      stage_q    <= stage_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      grp_q      <= grp_d;
      seq_wrap_q <= seq_wrap_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      q_const_q  <= q_const_d;
    end
  end

  assign Q        = q_q;
  assign Q_valid  = q_valid_q;
  assign Q_const  = q_const_q;
  assign grp_idx  = grp_q;
  assign seq_wrap = seq_wrap_q;

endmodule

// File: tb/tb_tw_seq_bank.sv
// Bench for tw_seq_bank: directed scenarios plus random traffic against a position/group reference model.
// Latency: outputs compared 1 ns after each rising edge against the model's prediction for that edge.
// Backpressure: n/a; CEN/run are driven directly.
module tb_tw_seq_bank;

  localparam logic [127:0] IDLE = 128'h1_0000000000000001;
  localparam int SWEEP = 4 * 16;  // run steps per group (DEPTH * REPEAT)

  logic         CLK = 1'b0;
  logic         rst;
  logic [2:0]   stage_counter;
  logic         CEN, run, wr_en, wr_hi;
  logic [1:0]   wr_kind;
  logic [2:0]   wr_stage;
  logic [1:0]   wr_grp, wr_idx;
  logic [63:0]  wr_data;
  logic [127:0] Q, Q_const;
  logic         Q_valid, seq_wrap;
  logic [1:0]   grp_idx;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [127:0] tbl_m [4][4][4];
  logic [127:0] const_m [4];
  int           gnum_m [4];
  int           pos, grp, last_s;
  logic [127:0] exp_q, exp_c;
  logic         exp_v, exp_w;

  tw_seq_bank dut (
    .CLK(CLK), .rst(rst), .stage_counter(stage_counter), .CEN(CEN), .run(run),
    .wr_en(wr_en), .wr_kind(wr_kind), .wr_hi(wr_hi), .wr_stage(wr_stage),
    .wr_grp(wr_grp), .wr_idx(wr_idx), .wr_data(wr_data),
    .Q(Q), .Q_valid(Q_valid), .Q_const(Q_const), .grp_idx(grp_idx), .seq_wrap(seq_wrap)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      const_m[s] = IDLE;
      gnum_m[s]  = 1;
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < 4; i++)
          tbl_m[s][g][i] = IDLE;
    end
    pos = 0; grp = 0; last_s = 0;
    exp_q = '0; exp_c = '0; exp_v = 1'b0; exp_w = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic model_step();
    int  s, gn;
    bit  ok, over;
    logic [1:0] si, gi, ii;
    s  = int'(stage_counter);
    ok = s < 4;
    si = stage_counter[1:0];
    gi = grp[1:0];
    ii = pos[1:0];  // position modulo DEPTH
    if (!CEN && ok) begin
      exp_q = tbl_m[si][gi][ii];
      exp_v = run;
      exp_c = const_m[si];
    end else begin
      exp_q = IDLE;
      exp_v = 1'b0;
    end
    gn    = ok ? gnum_m[si] : 1;
    exp_w = 1'b0;
    if (s != last_s) begin
      pos = 0;
      grp = 0;
    end else begin
      over = grp >= gn;
      if (!CEN) begin
        if (!run) pos = 0;
        else begin
          pos++;
          if (pos == SWEEP) begin
            pos = 0;
            if (!over) begin
              grp++;
              if (grp == gn) begin
                grp   = 0;
                exp_w = 1'b1;
              end
            end
          end
        end
      end
      if (over) grp = 0;
    end
    last_s = s;
    if (wr_en && wr_stage < 3'd4) begin
      case (wr_kind)
        2'd0: if (wr_hi) tbl_m[wr_stage[1:0]][wr_grp][wr_idx][127:64] = wr_data;
              else       tbl_m[wr_stage[1:0]][wr_grp][wr_idx][63:0]   = wr_data;
        2'd1: if (wr_hi) const_m[wr_stage[1:0]][127:64] = wr_data;
              else       const_m[wr_stage[1:0]][63:0]   = wr_data;
        2'd2: if (wr_data >= 64'd1 && wr_data <= 64'd4) gnum_m[wr_stage[1:0]] = int'(wr_data);
        default: ;
      endcase
    end
  endtask

  task automatic check_outs();
    chk_eq("Q", Q, exp_q);
    chk_eq("Q_valid", 128'(Q_valid), 128'(exp_v));
    chk_eq("Q_const", Q_const, exp_c);
    chk_eq("grp_idx", 128'(grp_idx), 128'(grp));
    chk_eq("seq_wrap", 128'(seq_wrap), 128'(exp_w));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_write(input logic [1:0] kind, input logic hi, input logic [2:0] st,
                          input logic [1:0] g, input logic [1:0] i, input logic [63:0] d);
    wr_en = 1'b1; wr_kind = kind; wr_hi = hi; wr_stage = st; wr_grp = g; wr_idx = i; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic apply_reset_now();
    rst = 1'b1;
    #1;
    chk_eq("rst_Q", Q, 128'd0);
    chk_eq("rst_Q_valid", 128'(Q_valid), 128'd0);
    chk_eq("rst_Q_const", Q_const, 128'd0);
    chk_eq("rst_grp_idx", 128'(grp_idx), 128'd0);
    chk_eq("rst_seq_wrap", 128'(seq_wrap), 128'd0);
    model_reset();
    @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  logic [127:0] w_idx2, w_new;
  int wc;

  initial begin
    rst = 1'b1; stage_counter = '0; CEN = 1'b1; run = 1'b0;
    wr_en = 1'b0; wr_kind = '0; wr_hi = 1'b0; wr_stage = '0; wr_grp = '0; wr_idx = '0; wr_data = '0;
    model_reset();
    #12;
    apply_reset_now();

    // 1) identity words stream out of a freshly reset bank
    stage_counter = 3'd0; CEN = 1'b0; run = 1'b1;
    run_cycles(8);

    // 2) load stage 0 group 0, then stream it
    CEN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [127:0] w;
      w = (i == 1) ? 128'hfffffffeffffffc1_52ca810d84ba33e7 : {$urandom, $urandom, $urandom, $urandom};
      if (i == 2) w_idx2 = w;
      do_write(2'd0, 1'b1, 3'd0, 2'd0, 2'(i), w[127:64]);
      do_write(2'd0, 1'b0, 3'd0, 2'd0, 2'(i), w[63:0]);
    end
    do_write(2'd1, 1'b1, 3'd0, 2'd0, 2'd0, 64'h0123456789abcdef);
    do_write(2'd1, 1'b0, 3'd0, 2'd0, 2'd0, 64'hfedcba9876543210);
    CEN = 1'b0; run = 1'b1;
    run_cycles(12);

    // 3) four groups on stage 1: group steps every 64 run cycles, one wrap per 256
    CEN = 1'b1;
    do_write(2'd2, 1'b0, 3'd1, 2'd0, 2'd0, 64'd4);
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 4; i++)
        do_write(2'd0, 1'(i & 1), 3'd1, 2'(g), 2'(i), {$urandom, $urandom});
    stage_counter = 3'd1; CEN = 1'b0; run = 1'b1;
    wc = 0;
    for (int k = 0; k < 262; k++) begin
      cycle();
      if (seq_wrap) wc++;
    end
    chk_eq("wrap_count", 128'(wc), 128'd1);

    // 4) run drop mid-sweep and CEN freeze
    run_cycles(70);
    run = 1'b0; run_cycles(2);
    run = 1'b1; run_cycles(5);
    CEN = 1'b1; run_cycles(4);
    CEN = 1'b0; run_cycles(3);

    // 5) same-cycle write of the word being read, then out-of-range stage
    stage_counter = 3'd0; CEN = 1'b1; run_cycles(1);
    CEN = 1'b0; run = 1'b1; run_cycles(2);
    w_new = {$urandom, $urandom, $urandom, $urandom};
    do_write(2'd0, 1'b1, 3'd0, 2'd0, 2'd2, w_new[127:64]);
    chk_eq("same_cycle_old", Q, w_idx2);
    run_cycles(3);
    do_write(2'd0, 1'b0, 3'd0, 2'd0, 2'd2, w_new[63:0]);
    run_cycles(4);
    chk_eq("new_visible", Q, w_new);
    stage_counter = 3'd5; run_cycles(4);

    // random traffic
    stage_counter = 3'd0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    stage_counter = 3'd0;
          2:       stage_counter = 3'd1;
          3:       stage_counter = 3'd2;
          4:       stage_counter = 3'd3;
          default: stage_counter = 3'd5;
        endcase
      end
      CEN = ($urandom_range(0, 9) == 0);
      run = ($urandom_range(0, 7) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_kind = 2'($urandom_range(0, 3));
      wr_hi = 1'($urandom);
      wr_stage = 3'($urandom_range(0, 4));
      wr_grp = 2'($urandom);
      wr_idx = 2'($urandom);
      wr_data = (wr_kind == 2'd2) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
      cycle();
    end
    wr_en = 1'b0;

    // 6) reset 37 cycles into a stream, then tables read back as identity
    stage_counter = 3'd0; CEN = 1'b0; run = 1'b1;
    run_cycles(37);
    apply_reset_now();
    stage_counter = 3'd1; run_cycles(2);
    stage_counter = 3'd0; run_cycles(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
